// File: rtl/if_fetch_unit.sv
// Instruction fetch: gathers one 32-bit word as four byte reads, little-endian,
// and presents it to decode with a valid/stall handshake and branch redirect.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  halt_req,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        mem_busy,
  input  logic [7:0]  mem_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] WORD_BYTES = CNT_W'(4);
  localparam logic [CNT_W-1:0] LAST_BYTE  = CNT_W'(3);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]       state, state_nx;
  logic [31:0]      pc, pc_nx;
  logic [CNT_W-1:0] issue_cnt, issue_nx;
  logic [CNT_W-1:0] recv_cnt, recv_nx;
  logic             pending, pending_nx;
  logic [31:0]      inst_buf, inst_buf_nx;
  logic             valid_nx;
  logic [31:0]      if_pc_nx, if_inst_nx;

  // Memory port is driven straight from state so a request can issue the cycle after a redirect.
  assign mem_req  = (state == FETCH) && (issue_cnt < WORD_BYTES);
  assign mem_addr = pc + 32'(issue_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      pending   <= 1'b0;
      inst_buf  <= '0;
      if_valid  <= 1'b0;
      if_pc     <= '0;
      if_inst   <= '0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      issue_cnt <= issue_nx;
      recv_cnt  <= recv_nx;
      pending   <= pending_nx;
      inst_buf  <= inst_buf_nx;
      if_valid  <= valid_nx;
      if_pc     <= if_pc_nx;
      if_inst   <= if_inst_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    issue_nx    = issue_cnt;
    recv_nx     = recv_cnt;
    pending_nx  = 1'b0;
    inst_buf_nx = inst_buf;
    valid_nx    = if_valid;
    if_pc_nx    = if_pc;
    if_inst_nx  = if_inst;

    case (state)
      IDLE: begin
        if (!halt_req[1]) state_nx = FETCH;
      end
      FETCH: begin
        if (mem_req && !mem_busy) begin
          issue_nx   = issue_cnt + CNT_W'(1);
          pending_nx = 1'b1;
        end
        if (pending) begin
          inst_buf_nx[{recv_cnt[1:0], 3'b000} +: 8] = mem_rdata;
          recv_nx = recv_cnt + CNT_W'(1);
          if (recv_cnt == LAST_BYTE) begin
            state_nx   = HOLD;
            valid_nx   = 1'b1;
            if_pc_nx   = pc;
            if_inst_nx = {mem_rdata, inst_buf[23:0]};
          end
        end
      end
      HOLD: begin
        if (!halt_req[0]) begin
          pc_nx    = pc + 32'd4;
          valid_nx = 1'b0;
          issue_nx = '0;
          recv_nx  = '0;
          state_nx = halt_req[1] ? IDLE : FETCH;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Redirect overrides everything, including a same-cycle acceptance.
    if (branch_flag) begin
      pc_nx      = branch_target;
      valid_nx   = 1'b0;
      issue_nx   = '0;
      recv_nx    = '0;
      pending_nx = 1'b0;
      state_nx   = halt_req[1] ? IDLE : FETCH;
    end
  end

endmodule
